// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package : mips_ctrl_pkg                                                  |
// | Purpose : Shared encodings for the multicycle MIPS main control FSM:     |
// |           state codes, supported opcodes, ALUOp / PCSource / ALUSrcB     |
// |           select codes, and the packed control-word type that the        |
// |           decoder hands back to the top.                                 |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
package mips_ctrl_pkg;

   // State encodings (exposed on the State debug port, so they are fixed)
   localparam logic [3:0] IDLE   = 4'd0;
   localparam logic [3:0] FETCH  = 4'd1;
   localparam logic [3:0] DECODE = 4'd2;
   localparam logic [3:0] MEMADR = 4'd3;
   localparam logic [3:0] MEMRD  = 4'd4;
   localparam logic [3:0] MEMWB  = 4'd5;
   localparam logic [3:0] MEMWR  = 4'd6;
   localparam logic [3:0] EXEC   = 4'd7;
   localparam logic [3:0] RWB    = 4'd8;
   localparam logic [3:0] BRANCH = 4'd9;
   localparam logic [3:0] JUMP   = 4'd10;
   localparam logic [3:0] ADDIEX = 4'd11;
   localparam logic [3:0] ADDIWB = 4'd12;

   // Supported opcodes (instruction bits [31:26])
   localparam logic [5:0] RTYPE = 6'h00;
   localparam logic [5:0] LW    = 6'h23;
   localparam logic [5:0] SW    = 6'h2B;
   localparam logic [5:0] BEQ   = 6'h04;
   localparam logic [5:0] J     = 6'h02;
   localparam logic [5:0] ADDI  = 6'h08;

   // ALU control select
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU B operand select
   localparam logic [1:0] ALUB_REGB  = 2'b00;
   localparam logic [1:0] ALUB_FOUR  = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_IMMS2 = 2'b11;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       irwrite;
      logic       alusrca;
      logic       regwrite;
      logic       regdst;
      logic [1:0] pcsource;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
   } ctrl_t;

   // True for the opcodes this controller knows how to sequence
   function automatic logic is_supported_op(input logic [5:0] op);
      return (op == RTYPE) || (op == LW) || (op == SW) ||
             (op == BEQ) || (op == J) || (op == ADDI);
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : control_decode                                                 |
// | Purpose : Purely combinational map from the FSM state (plus MemReady,    |
// |           which gates IRWrite/PCWrite during FETCH) to the datapath      |
// |           control word. Every field defaults to 0 so each state lists    |
// |           only the controls it asserts.                                  |
// | Ports   : State    in  4  current FSM state                              |
// |           MemReady in  1  memory completion strobe                       |
// |           ctrl     out    packed control word (ctrl_t)                   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module control_decode
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] State,
   input  logic       MemReady,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (State)
         FETCH: begin
            ctrl.memread  = 1'b1;
            ctrl.iord     = 1'b0;
            ctrl.alusrca  = 1'b0;
            ctrl.alusrcb  = ALUB_FOUR;
            ctrl.aluop    = ALUOP_ADD;
            ctrl.pcsource = PCSRC_ALU;
            // IR and PC must only capture once the fetch data is valid
            ctrl.irwrite  = MemReady;
            ctrl.pcwrite  = MemReady;
         end
         DECODE: begin
            ctrl.alusrca = 1'b0;
            ctrl.alusrcb = ALUB_IMMS2;
            ctrl.aluop   = ALUOP_ADD;
         end
         MEMADR, ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         MEMRD: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         MEMWR: begin
            ctrl.memwrite = 1'b1;
            ctrl.iord     = 1'b1;
         end
         EXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = ALUB_REGB;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         RWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         BRANCH: begin
            ctrl.alusrca     = 1'b1;
            ctrl.alusrcb     = ALUB_REGB;
            ctrl.aluop       = ALUOP_SUB;
            ctrl.pcwritecond = 1'b1;
            ctrl.pcsource    = PCSRC_ALUOUT;
         end
         JUMP: begin
            ctrl.pcwrite  = 1'b1;
            ctrl.pcsource = PCSRC_JUMP;
         end
         ADDIWB: begin
            ctrl.regwrite = 1'b1;
         end
         default: ctrl = '0;   // IDLE and unused codes
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : main_control_fsm                                               |
// | Purpose : Main Moore control FSM for a multicycle MIPS datapath.         |
// |           Holds the state register, next-state logic and the sticky      |
// |           IllegalOp flag; output decode lives in control_decode.         |
// | Ports   : clk, reset (async, active high)                                |
// |           Op[5:0], MemReady                                              |
// |           PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,       |
// |           IRWrite, ALUSrcA, RegWrite, RegDst, PCSource[1:0],             |
// |           ALUSrcB[1:0], ALUOp[1:0], IllegalOp, State[3:0]                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module main_control_fsm
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [1:0] PCSource,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       IllegalOp,
   output logic [3:0] State
);

   logic [3:0] r_state;
   logic [3:0] w_next_state;
   logic       r_illegal;
   logic       w_illegal_seen;
   ctrl_t      w_ctrl;

   // Op is held stable by the datapath for the whole instruction, so it is
   // used directly here rather than captured in DECODE.
   always_comb begin
      w_next_state   = FETCH;
      w_illegal_seen = 1'b0;
      case (r_state)
         IDLE:   w_next_state = FETCH;
         FETCH:  w_next_state = MemReady ? DECODE : FETCH;
         DECODE: begin
            case (Op)
               RTYPE:   w_next_state = EXEC;
               LW, SW:  w_next_state = MEMADR;
               BEQ:     w_next_state = BRANCH;
               J:       w_next_state = JUMP;
               ADDI:    w_next_state = ADDIEX;
               default: w_next_state = FETCH;
            endcase
            w_illegal_seen = !is_supported_op(Op);
         end
         MEMADR: w_next_state = (Op == SW) ? MEMWR : MEMRD;
         MEMRD:  w_next_state = MemReady ? MEMWB : MEMRD;
         MEMWR:  w_next_state = MemReady ? FETCH : MEMWR;
         EXEC:   w_next_state = RWB;
         ADDIEX: w_next_state = ADDIWB;
         default: w_next_state = FETCH;   // single-cycle tails and codes 13-15
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_illegal_seen) begin
            r_illegal <= 1'b1;
         end
      end
   end

   control_decode u_decode (
      .State    (r_state),
      .MemReady (MemReady),
      .ctrl     (w_ctrl)
   );

   assign PCWrite     = w_ctrl.pcwrite;
   assign PCWriteCond = w_ctrl.pcwritecond;
   assign IorD        = w_ctrl.iord;
   assign MemRead     = w_ctrl.memread;
   assign MemWrite    = w_ctrl.memwrite;
   assign MemtoReg    = w_ctrl.memtoreg;
   assign IRWrite     = w_ctrl.irwrite;
   assign ALUSrcA     = w_ctrl.alusrca;
   assign RegWrite    = w_ctrl.regwrite;
   assign RegDst      = w_ctrl.regdst;
   assign PCSource    = w_ctrl.pcsource;
   assign ALUSrcB     = w_ctrl.alusrcb;
   assign ALUOp       = w_ctrl.aluop;
   assign IllegalOp   = r_illegal;
   assign State       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : tb_main_control_fsm                                            |
// | Purpose : Self-checking bench for main_control_fsm. An instruction-level |
// |           model (per-opcode list of states to visit, memory-wait holds)  |
// |           predicts State/IllegalOp/controls each cycle; directed         |
// |           sequences pin the model with literal values.                   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_main_control_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'h00;
   logic       memready = 1'b0;

   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, ALUSrcA, RegWrite, RegDst, IllegalOp;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic [3:0] State;

   always #5 clk = ~clk;

   main_control_fsm dut (
      .clk         (clk),
      .reset       (reset),
      .Op          (op),
      .MemReady    (memready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .PCSource    (PCSource),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .IllegalOp   (IllegalOp),
      .State       (State)
   );

   wire [15:0] dut_out = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_state = 0;      // state the DUT should be in this cycle
   bit         m_ill = 1'b0;
   bit         need_new = 1'b0;  // just returned to FETCH: choose next opcode
   bit         cur_illegal = 1'b0;
   int         seq[$];           // states still to visit after the current one
   logic [5:0] op_plan[$];
   bit         run_chk = 1'b0;

   // Control word each state must present, written field by field
   function automatic logic [15:0] exp_out(input int st, input bit mr);
      bit pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
      bit [1:0] pcs, asb, aop;
      {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
      pcs = 0; asb = 0; aop = 0;
      case (st)
         1:  begin mrd = 1; asb = 1; irw = mr; pcw = mr; end
         2:  asb = 3;
         3:  begin asa = 1; asb = 2; end
         4:  begin mrd = 1; iord = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mwr = 1; iord = 1; end
         7:  begin asa = 1; aop = 2; end
         8:  begin rw = 1; rd = 1; end
         9:  begin asa = 1; aop = 1; pcwc = 1; pcs = 1; end
         10: begin pcw = 1; pcs = 2; end
         11: begin asa = 1; asb = 2; end
         12: rw = 1;
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
   endfunction

   // Path of an instruction after FETCH, by opcode
   task automatic build_path(input logic [5:0] o);
      seq.delete();
      cur_illegal = 1'b0;
      seq.push_back(2);
      case (o)
         6'h00: begin seq.push_back(7); seq.push_back(8); end
         6'h23: begin seq.push_back(3); seq.push_back(4); seq.push_back(5); end
         6'h2B: begin seq.push_back(3); seq.push_back(6); end
         6'h04: seq.push_back(9);
         6'h02: seq.push_back(10);
         6'h08: begin seq.push_back(11); seq.push_back(12); end
         default: cur_illegal = 1'b1;
      endcase
   endtask

   // Advance the model by one clock edge using the inputs the DUT just sampled
   task automatic model_update();
      int prev;
      prev = m_state;
      if ((prev == 1 || prev == 4 || prev == 6) && !memready) begin
         // memory wait: stay put
      end else if (seq.size() > 0) begin
         m_state = seq.pop_front();
      end else begin
         if (prev == 2 && cur_illegal) m_ill = 1'b1;
         m_state  = 1;
         need_new = 1'b1;
      end
   endtask

   function automatic logic [5:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 6'h00;
         1: return 6'h23;
         2: return 6'h2B;
         3: return 6'h04;
         4: return 6'h02;
         5: return 6'h08;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   // One clock: advance model at the edge, then drive inputs for the new cycle
   task automatic cyc(input bit mr);
      logic [5:0] o;
      @(posedge clk);
      model_update();
      #1;
      if (need_new) begin
         need_new = 1'b0;
         if (op_plan.size() > 0) o = op_plan.pop_front();
         else o = rand_op();
         op = o;
         build_path(o);
      end
      memready = mr;
      #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_outputs", int'(dut_out), 0);
      chk("rst_state", int'(State), 0);
      chk("rst_illegal", int'(IllegalOp), 0);
      m_state = 0;
      m_ill = 1'b0;
      need_new = 1'b0;
      seq.delete();
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (run_chk && !reset) begin
         chk("state", int'(State), m_state);
         chk("illegalop", int'(IllegalOp), int'(m_ill));
         chk("controls", int'(dut_out), int'(exp_out(m_state, memready)));
      end
   end

   initial begin
      op_plan = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h3F, 6'h02, 6'h08, 6'h23};
      #3;
      chk("init_outputs", int'(dut_out), 0);
      chk("init_state", int'(State), 0);
      chk("init_illegal", int'(IllegalOp), 0);
      @(negedge clk);
      #1 reset = 1'b0;
      run_chk = 1'b1;

      // lw with MemReady high: 1,2,3,4,5,1
      cyc(1); chk("lw_s1", int'(State), 1);
      cyc(1); chk("lw_s2", int'(State), 2);
      cyc(1); chk("lw_s3", int'(State), 3);
      cyc(1); chk("lw_s4", int'(State), 4);
      cyc(1); chk("lw_s5", int'(State), 5);
      chk("lw_regwrite", int'(RegWrite), 1);
      chk("lw_memtoreg", int'(MemtoReg), 1);
      cyc(1); chk("lw_back", int'(State), 1);
      chk("lw_after_regwrite", int'(RegWrite), 0);

      // sw with three wait cycles in MEMWR
      cyc(1); chk("sw_s2", int'(State), 2);
      cyc(1); chk("sw_s3", int'(State), 3);
      for (int i = 0; i < 4; i++) begin
         cyc(i == 3);
         chk("sw_memwr_state", int'(State), 6);
         chk("sw_memwrite", int'(MemWrite), 1);
      end
      cyc(1); chk("sw_back", int'(State), 1);

      // R-type
      cyc(1); chk("r_s2", int'(State), 2);
      cyc(1); chk("r_exec", int'(State), 7); chk("r_aluop", int'(ALUOp), 2);
      cyc(1); chk("r_rwb", int'(State), 8);
      chk("r_regdst", int'(RegDst), 1); chk("r_regwrite", int'(RegWrite), 1);
      cyc(1); chk("r_back", int'(State), 1);

      // beq
      cyc(1); chk("beq_s2", int'(State), 2);
      cyc(1); chk("beq_s9", int'(State), 9);
      chk("beq_aluop", int'(ALUOp), 1); chk("beq_pcwc", int'(PCWriteCond), 1);
      cyc(1); chk("beq_back", int'(State), 1); chk("beq_pcwc_off", int'(PCWriteCond), 0);

      // illegal opcode, then j
      cyc(1); chk("ill_s2", int'(State), 2); chk("ill_before", int'(IllegalOp), 0);
      cyc(1); chk("ill_back", int'(State), 1); chk("ill_set", int'(IllegalOp), 1);
      cyc(1); chk("j_s2", int'(State), 2);
      cyc(1); chk("j_s10", int'(State), 10);
      chk("j_pcwrite", int'(PCWrite), 1); chk("j_pcsource", int'(PCSource), 2);
      chk("j_illegal_sticky", int'(IllegalOp), 1);
      cyc(1); chk("j_back", int'(State), 1);

      // addi, then FETCH with two MemReady-low cycles
      cyc(1); chk("addi_s2", int'(State), 2);
      cyc(1); chk("addi_s11", int'(State), 11);
      cyc(1); chk("addi_s12", int'(State), 12); chk("addi_regwrite", int'(RegWrite), 1);
      cyc(0); chk("fw0_irw", int'(IRWrite), 0); chk("fw0_pcw", int'(PCWrite), 0);
      cyc(0); chk("fw1_state", int'(State), 1); chk("fw1_irw", int'(IRWrite), 0);
      cyc(1); chk("fw2_state", int'(State), 1);
      chk("fw2_irw", int'(IRWrite), 1); chk("fw2_pcw", int'(PCWrite), 1);
      cyc(1); chk("fw3_state", int'(State), 2); chk("fw3_irw", int'(IRWrite), 0);

      // lw stalled in MEMRD, then reset mid-wait
      cyc(1); chk("rd_s3", int'(State), 3);
      cyc(0); chk("rd_s4", int'(State), 4);
      cyc(0); chk("rd_hold", int'(State), 4);
      do_reset();
      cyc(1); chk("rst_to_fetch", int'(State), 1);

      // randomized run
      repeat (3000) begin
         cyc($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
